// File: rtl/led_blink_gen.sv
// Multi-channel clock divider driving one LED per channel in OFF/TOGGLE/PULSE/PWM mode, gated by PLL lock.
// Outputs are registered (one edge after the counting edge); there is no backpressure because channels free-run while o_run & i_en.
module led_blink_gen #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_locked,
  input  logic [N_CH-1:0]       i_en,
  input  logic [2*N_CH-1:0]     i_mode,
  input  logic [CNT_W*N_CH-1:0] i_div,
  input  logic [CNT_W*N_CH-1:0] i_duty,
  output logic [N_CH-1:0]       o_led,
  output logic [N_CH-1:0]       o_tick,
  output logic                  o_run
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_PWM    = 2'b11
  } mode_e;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] duty;
    mode_e            mode;
  } cfg_t;

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
  end

  assign o_run = r_sync[SYNC_STAGES-1];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    cfg_t             r_cfg;
    cfg_t             w_cfg_in;
    logic             r_led;
    logic             r_tick;
    logic             w_active;
    logic             w_wrap;
    logic             w_led_nxt;

    assign w_cfg_in.div  = i_div[k*CNT_W +: CNT_W];
    assign w_cfg_in.duty = i_duty[k*CNT_W +: CNT_W];
    assign w_cfg_in.mode = mode_e'(i_mode[2*k +: 2]);

    assign w_active = o_run & i_en[k];
    assign w_wrap   = (r_cnt == r_cfg.div);

    always_comb begin
      w_led_nxt = 1'b0;
      case (r_cfg.mode)
        MODE_OFF:    w_led_nxt = 1'b0;
        MODE_TOGGLE: w_led_nxt = w_wrap ? ~r_led : r_led;
        MODE_PULSE:  w_led_nxt = w_wrap;
        MODE_PWM:    w_led_nxt = (r_cnt < r_cfg.duty);
        default:     w_led_nxt = 1'b0;
      endcase
    end

    // Config is only sampled at a period boundary or while idle, so a period is never cut short.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt  <= '0;
        r_cfg  <= '0;
        r_led  <= 1'b0;
        r_tick <= 1'b0;
      end else if (!w_active) begin
        r_cnt  <= '0;
        r_cfg  <= w_cfg_in;
        r_led  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        r_tick <= w_wrap;
        r_led  <= w_led_nxt;
        if (w_wrap) r_cfg <= w_cfg_in;
      end
    end

    assign o_led[k]  = r_led;
    assign o_tick[k] = r_tick;
  end

endmodule

// File: tb/tb_led_blink_gen.sv
// Bench for led_blink_gen: a cycle model feeds an expected-output queue, and each scenario adds timing checks.
module tb_led_blink_gen;
  localparam int N = 2;
  localparam int W = 16;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           locked;
  logic [N-1:0]   en;
  logic [2*N-1:0] mode;
  logic [W*N-1:0] div;
  logic [W*N-1:0] duty;
  logic [N-1:0]   o_led;
  logic [N-1:0]   o_tick;
  logic           o_run;

  int total = 0;
  int bad   = 0;

  led_blink_gen #(.N_CH(N), .CNT_W(W), .SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_locked(locked), .i_en(en), .i_mode(mode),
    .i_div(div), .i_duty(duty), .o_led(o_led), .o_tick(o_tick), .o_run(o_run)
  );

  always #5 clk = ~clk;

  // Reference model state and expected-output queue {run, led[1:0], tick[1:0]}
  logic [S-1:0] m_sync;
  int unsigned  m_cnt [N];
  int unsigned  m_div [N];
  int unsigned  m_duty[N];
  logic [1:0]   m_mode[N];
  logic [N-1:0] m_led;
  logic [N-1:0] m_tick;
  logic [4:0]   sb[$];

  task automatic model_step();
    if (!rst_n) begin
      m_sync = '0;
      m_led  = '0;
      m_tick = '0;
      for (int k = 0; k < N; k++) begin
        m_cnt[k] = 0; m_div[k] = 0; m_duty[k] = 0; m_mode[k] = 2'b00;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!(m_sync[S-1] && en[k])) begin
          m_cnt[k]  = 0;
          m_led[k]  = 1'b0;
          m_tick[k] = 1'b0;
          m_div[k]  = div[k*W +: W];
          m_duty[k] = duty[k*W +: W];
          m_mode[k] = mode[2*k +: 2];
        end else begin
          logic last;
          last = (m_cnt[k] == m_div[k]);
          case (m_mode[k])
            2'b01:   if (last) m_led[k] = ~m_led[k];
            2'b10:   m_led[k] = last;
            2'b11:   m_led[k] = (m_cnt[k] < m_duty[k]);
            default: m_led[k] = 1'b0;
          endcase
          m_tick[k] = last;
          if (last) begin
            m_cnt[k]  = 0;
            m_div[k]  = div[k*W +: W];
            m_duty[k] = duty[k*W +: W];
            m_mode[k] = mode[2*k +: 2];
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
      m_sync = {m_sync[S-2:0], locked};
    end
    sb.push_back({m_sync[S-1], m_led, m_tick});
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    int rise;
    rst_n = 1'b0; locked = 1'b1; en = '0; mode = '0; div = '0; duty = '0;
    #1;
    total++;
    if ({o_run, o_led, o_tick} !== 5'b0) begin
      bad++; $display("FAIL reset_state got=%b exp=00000", {o_run, o_led, o_tick});
    end
    for (int i = 0; i < 3; i++) begin
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL reset_hold i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
    end
    rst_n = 1'b1;
    rise  = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin div[15:0] = 16'd3; mode[1:0] = 2'b01; end
      if (i == 4) en = 2'b01;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL reset_run i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (o_run && rise < 0) rise = i + 1;
    end
    total++;
    if (rise < 0 || rise > S + 1) begin
      bad++; $display("FAIL run_rise got=%0d cycles exp<=%0d", rise, S + 1);
    end
    // Asynchronous reset mid-run, away from any clock edge
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_run, o_led, o_tick} !== 5'b0) begin
      bad++; $display("FAIL async_reset got=%b exp=00000", {o_run, o_led, o_tick});
    end
    clk_step();
    exp = sb.pop_front(); total++;
    if ({o_run, o_led, o_tick} !== exp) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b", {o_run, o_led, o_tick}, exp);
    end
    rst_n = 1'b1;
    rise  = -1;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL rerun i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (o_run && rise < 0) rise = i + 1;
    end
    total++;
    if (rise < 0 || rise > S + 1) begin
      bad++; $display("FAIL rerun_rise got=%0d cycles exp<=%0d", rise, S + 1);
    end
  endtask

  task automatic test_toggle();
    logic [4:0] exp;
    logic pl;
    int tq[$];
    int et;
    en = '0; pl = 1'b0;
    tq = {31, 61, 91, 121};
    for (int i = 0; i < 130; i++) begin
      if (i == 1) begin div[15:0] = 16'd29; mode[1:0] = 2'b01; end
      if (i == 2) en = 2'b01;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL toggle i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (o_tick[0]) begin
        et = -1;
        if (tq.size() > 0) et = tq.pop_front();
        total++;
        if (et != i) begin bad++; $display("FAIL toggle_tick got=%0d exp=%0d", i, et); end
      end
      if (o_led[0] !== pl) begin
        total++;
        if (o_tick[0] !== 1'b1) begin
          bad++; $display("FAIL toggle_edge i=%0d tick=%b exp=1", i, o_tick[0]);
        end
      end
      pl = o_led[0];
    end
    total++;
    if (tq.size() != 0) begin bad++; $display("FAIL toggle_missing got=%0d left exp=0", tq.size()); end
  endtask

  task automatic test_pwm();
    logic [4:0] exp;
    int hc[4];
    int w;
    en = '0;
    for (int j = 0; j < 4; j++) hc[j] = 0;
    for (int i = 0; i < 122; i++) begin
      if (i == 1) begin div[31:16] = 16'd29; duty[31:16] = 16'd10; mode[3:2] = 2'b11; end
      if (i == 2) en = 2'b10;
      if (i == 40) duty[31:16] = 16'd0;
      if (i == 70) duty[31:16] = 16'd31;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL pwm i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (i >= 2) begin
        w = (i - 2) / 30;
        if (o_led[1] === 1'b1) hc[w]++;
      end
    end
    total++; if (hc[0] != 10) begin bad++; $display("FAIL pwm_d10a got=%0d exp=10", hc[0]); end
    total++; if (hc[1] != 10) begin bad++; $display("FAIL pwm_d10b got=%0d exp=10", hc[1]); end
    total++; if (hc[2] != 0)  begin bad++; $display("FAIL pwm_d0 got=%0d exp=0", hc[2]); end
    total++; if (hc[3] != 30) begin bad++; $display("FAIL pwm_d31 got=%0d exp=30", hc[3]); end
  endtask

  task automatic test_div_change();
    logic [4:0] exp;
    int tq[$];
    int et;
    en = '0; duty = '0;
    tq = {31, 61, 71, 81, 91};
    for (int i = 0; i < 100; i++) begin
      if (i == 1) begin div[15:0] = 16'd29; mode[1:0] = 2'b01; end
      if (i == 2) en = 2'b01;
      if (i == 37) div[15:0] = 16'd9;
      if (i == 75) mode[1:0] = 2'b10;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL divchg i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (o_tick[0]) begin
        et = -1;
        if (tq.size() > 0) et = tq.pop_front();
        total++;
        if (et != i) begin bad++; $display("FAIL divchg_tick got=%0d exp=%0d", i, et); end
      end
      if (i >= 82) begin
        total++;
        if (o_led[0] !== o_tick[0]) begin
          bad++; $display("FAIL modechg i=%0d led=%b exp=%b", i, o_led[0], o_tick[0]);
        end
      end
    end
    total++;
    if (tq.size() != 0) begin bad++; $display("FAIL divchg_missing got=%0d left exp=0", tq.size()); end
  endtask

  task automatic test_lock();
    logic [4:0] exp;
    int tq[$];
    int et;
    en = '0;
    tq = {11, 21, 31, 42, 52};
    for (int i = 0; i < 55; i++) begin
      if (i == 1) begin
        div = {16'd9, 16'd9}; duty[31:16] = 16'd4; mode = 4'b1101;
      end
      if (i == 2) en = 2'b11;
      if (i == 30) locked = 1'b0;
      if (i == 31) locked = 1'b1;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL lock i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if (o_tick[0]) begin
        et = -1;
        if (tq.size() > 0) et = tq.pop_front();
        total++;
        if (et != i) begin bad++; $display("FAIL lock_tick got=%0d exp=%0d", i, et); end
      end
      if (i == 31) begin
        total++;
        if (o_run !== 1'b0) begin bad++; $display("FAIL lock_drop run=%b exp=0", o_run); end
      end
      if (i == 32) begin
        total++;
        if ({o_run, o_led, o_tick} !== 5'b10000) begin
          bad++; $display("FAIL lock_clear got=%b exp=10000", {o_run, o_led, o_tick});
        end
      end
    end
    total++;
    if (tq.size() != 0) begin bad++; $display("FAIL lock_missing got=%0d left exp=0", tq.size()); end
  endtask

  task automatic test_div0();
    logic [4:0] exp;
    en = '0; div = '0; mode = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) mode[1:0] = 2'b10;
      if (i == 2) en = 2'b01;
      if (i == 10) en = 2'b00;
      if (i == 12) en = 2'b01;
      clk_step();
      exp = sb.pop_front(); total++;
      if ({o_run, o_led, o_tick} !== exp) begin
        bad++; $display("FAIL div0 i=%0d got=%b exp=%b", i, {o_run, o_led, o_tick}, exp);
      end
      if ((i >= 2 && i <= 9) || i >= 12) begin
        total++;
        if ({o_led[0], o_tick[0]} !== 2'b11) begin
          bad++; $display("FAIL div0_high i=%0d got=%b exp=11", i, {o_led[0], o_tick[0]});
        end
      end
      if (i == 10 || i == 11) begin
        total++;
        if ({o_led[0], o_tick[0]} !== 2'b00) begin
          bad++; $display("FAIL div0_en_off i=%0d got=%b exp=00", i, {o_led[0], o_tick[0]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_pwm();
    test_div_change();
    test_lock();
    test_div0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
